// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: MD latency defaults,
// tracker state encoding and the register-dependence helper.
package hazard_pkg;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
  localparam int CNT_W_DEF    = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // $0 is never a real producer, so it never creates a dependence.
  function automatic logic reg_dep(input logic [4:0] wr,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt);
    return (wr != 5'd0) && ((wr == rs) || (wr == rt));
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Tracks the multi-cycle multiply/divide unit: busy for LAT cycles after an
// issue, with a done pulse on the last busy cycle.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic op_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A start while busy is dropped; correct stalling keeps it from happening.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          count_d = op_div_i ? DIV_CNT : MULT_CNT;
        end
      end
      MD_BUSY: begin
        if (count_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_o = (state_q == MD_BUSY);
    done_o = (state_q == MD_BUSY) && (count_q == '0);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/decode-forward generator for the 5-stage pipeline; covers the
// hazards execute-stage forwarding cannot resolve, including MD latency.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] writeRegisterE,
  input  logic [4:0] writeRegisterM,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       branchD,
  input  logic       pcSrcD,
  input  logic       hiLoReadD,
  input  logic       mdStartD,
  input  logic       mdStartE,
  input  logic       mdOpE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       mdBusy,
  output logic       mdDone
);

  logic lw_stall;
  logic branch_stall;
  logic md_stall;
  logic stall;

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_counter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mdStartE),
    .op_div_i (mdOpE),
    .busy_o   (mdBusy),
    .done_o   (mdDone)
  );

  // Decode-stage compares need operands a cycle earlier than the ALU does, so
  // any E-stage producer or M-stage load blocks the branch.
  always_comb begin
    lw_stall     = memToRegE & regWriteE & reg_dep(writeRegisterE, rsD, rtD);
    branch_stall = branchD &
                   ((regWriteE & reg_dep(writeRegisterE, rsD, rtD)) |
                    (memToRegM & reg_dep(writeRegisterM, rsD, rtD)));
    md_stall     = (mdBusy | mdStartE) & (hiLoReadD | mdStartD);
    stall        = lw_stall | branch_stall | md_stall;
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  // A stalled branch re-evaluates next cycle; flushing now would kill its slot.
  assign flushD = pcSrcD & ~stall;

  assign forwardAD = regWriteM & ~memToRegM & (writeRegisterM != 5'd0) &
                     (writeRegisterM == rsD);
  assign forwardBD = regWriteM & ~memToRegM & (writeRegisterM != 5'd0) &
                     (writeRegisterM == rtD);

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Stall/flush generator for the 5-stage MIPS pipeline; complements the execute-stage forwarding logic by handling every hazard forwarding cannot resolve. Detects load-use and branch-compare hazards, drives decode-stage branch operand forwarding, and tracks the multi-cycle multiply/divide unit with a busy counter so HI/LO consumers and back-to-back mul/div ops stall until the result is written. Sits beside the pipeline registers and drives their enable and flush inputs directly.

## Interface
- MULT_LAT, 4, multiply latency in cycles (≥2)
- DIV_LAT, 32, divide latency in cycles (≥2, ≤ 2^CNT_W)
- CNT_W, 6, busy counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  5  decode-stage source registers
- writeRegisterE, writeRegisterM  in  5  destination register in E, M
- regWriteE, regWriteM  in  1  register write enable in E, M
- memToRegE, memToRegM  in  1  instruction in E, M is a load
- branchD  in  1  branch (beq/bne) in decode; compare done in D
- pcSrcD  in  1  branch/jump resolved taken in D
- hiLoReadD  in  1  mfhi/mflo in decode
- mdStartD  in  1  mult/div in decode
- mdStartE  in  1  mult/div issuing to the MD unit this cycle
- mdOpE  in  1  0 = mult, 1 = div
- stallF, stallD  out  1  hold PC / IF-ID register
- flushD, flushE  out  1  clear IF-ID / ID-EX register (insert bubble)
- forwardAD, forwardBD  out  1  forward M-stage ALU result to decode compare operand A/B
- mdBusy  out  1  MD unit computing
- mdDone  out  1  one-cycle pulse, last busy cycle

## Operation
- lwStall = memToRegE & regWriteE & (writeRegisterE≠0) & (writeRegisterE==rsD | writeRegisterE==rtD).
- branchStall = branchD & [(regWriteE & writeRegisterE≠0 & writeRegisterE∈{rsD,rtD}) | (memToRegM & writeRegisterM≠0 & writeRegisterM∈{rsD,rtD})].
- forwardAD = regWriteM & ~memToRegM & writeRegisterM≠0 & writeRegisterM==rsD; forwardBD same with rtD.
- mdStall = (mdBusy | mdStartE) & (hiLoReadD | mdStartD).
- stall = lwStall | branchStall | mdStall; stallF = stallD = stall; flushE = stall.
- flushD = pcSrcD & ~stallD (a stalled branch must not flush its own successor slot).
- MD tracker FSM, states IDLE, BUSY:
  - IDLE: mdStartE → load count = (mdOpE ? DIV_LAT : MULT_LAT) − 1, go BUSY.
  - BUSY: count decrements each cycle; count==0 → mdDone=1, go IDLE next cycle.
  - mdStartE while BUSY: ignored (cannot occur under correct stalling); counter unaffected.
- mdBusy = (state==BUSY); mdDone = BUSY & count==0.
- All outputs except mdBusy/mdDone are combinational from current inputs and mdBusy.

## Timing
- Reset: state IDLE, count 0, mdBusy 0, mdDone 0; combinational outputs then 0 for idle inputs. rst mid-operation aborts the counter in one cycle; stalls from the MD tracker drop the next cycle.
- mdStartE at cycle t (IDLE): mdBusy=1 cycles t+1 … t+LAT; mdDone=1 at t+LAT; mdBusy=0 at t+LAT+1.
- mfhi in D at any cycle t … t+LAT is stalled; leaves D at t+LAT+1 earliest.
- Load-use: exactly one stall cycle per load followed by dependent instruction.
- Branch depending on E-stage ALU op: 1 stall; on E-stage load: 2 stalls (E then M term).
- rst and mdStartE same cycle: rst wins.

## Structure
- Shared package hazard_pkg: MULT_LAT/DIV_LAT defaults, md state encoding (IDLE=0, BUSY=1).
- One sub-module: md_busy_counter (FSM + down-counter, outputs mdBusy, mdDone); hazard equations in the top.

## Test plan
- lw $2 (E, writeRegisterE=2, memToRegE=1) with rsD=2 → stallF=stallD=flushE=1 for one cycle; rsD=0 with writeRegisterE=0 → no stall.
- beq rsD=3, writeRegisterE=3 regWriteE=1 → stall; next cycle writeRegisterM=3, memToRegM=0 → no stall, forwardAD=1.
- mult (mdStartE=1, mdOpE=0) at t → mdBusy t+1..t+4, mdDone at t+4; hiLoReadD=1 held → stall t..t+4, released t+5.
- div at t, mdStartD=1 in same cycle → stall t..t+32, mdDone at t+32.
- pcSrcD=1 with stall=0 → flushD=1; pcSrcD=1 with branchStall=1 → flushD=0.
- rst at t+2 during div → mdBusy=0 at t+3, mfhi stall released at t+3.
